// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/memory-stage arbiter for a single-port unified RAM
// Optional fetch starvation guard: define MEM_PORT_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_pc,
  output logic              busy
);

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: RD_LAT must be 1..4 and STARVE_MAX >= 1");
  end

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_own;
  logic              w_if_gnt;
  logic              w_mem_gnt;
  logic              w_force;
  logic              w_last_vld;
  logic              w_last_own;

`ifdef MEM_PORT_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve;

  // At the limit the next grant goes to fetch; that grant clears the count.
  assign w_force = if_req && (r_starve == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_mem_gnt = !rst && mem_req && !w_force;
    w_if_gnt  = !rst && if_req && !w_mem_gnt;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_mem_gnt) begin
      ram_addr = mem_addr;
      ram_we   = mem_we;
      if (mem_we) ram_wdata = mem_wdata;
    end else if (w_if_gnt) begin
      ram_addr = if_addr;
    end
  end

  // Flush kills fetch-owned stages as they shift; stage 0 always takes the new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_if_gnt || (w_mem_gnt && !mem_we);
      r_own[0] <= w_mem_gnt ? OWN_MEM : OWN_IF;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1] && !(flush && (r_own[i-1] == OWN_IF));
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign w_last_vld = r_vld[RD_LAT-1];
  assign w_last_own = r_own[RD_LAT-1];

  always_comb begin
    if_rvalid  = w_last_vld && (w_last_own == OWN_IF) && !flush;
    mem_rvalid = w_last_vld && (w_last_own == OWN_MEM);
    if_rdata   = if_rvalid ? ram_rdata : '0;
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end

  assign if_gnt   = w_if_gnt;
  assign mem_gnt  = w_mem_gnt;
  assign stall_pc = !rst && if_req && !w_if_gnt;
  assign busy     = |r_vld;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Includes a 2-cycle-latency RAM model; RAM[a] = 0xC0DE0000 | a except RAM[0x010] = 0xE3A01005.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              stall_pc;
  logic              busy;

  int n_cmp;
  int n_fail;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_pc(stall_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              ram_init_done = 1'b0;
  logic [DATA_W-1:0] rd_p0;
  logic [DATA_W-1:0] rd_p1;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int a = 0; a < (1 << ADDR_W); a++) ram[a] <= 32'hC0DE0000 | 32'(a);
      ram[11'h010] <= 32'hE3A01005;
      ram_init_done <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    rd_p0 <= ram[ram_addr];
    rd_p1 <= rd_p0;
  end
  assign ram_rdata = rd_p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] starve_exp;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);

    // reset: requests present but every output held low
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b1; mem_addr = 11'h123; mem_wdata = 32'h5555AAAA;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_mem_gnt", 32'(mem_gnt), 0);
    chk("rst_stall", 32'(stall_pc), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    chk("idle_ram_addr", 32'(ram_addr), 0);
    chk("idle_ram_wdata", ram_wdata, 0);
    tick();

    // fetch-only read
    if_req = 1'b1; if_addr = 11'h010;
    #1;
    chk("f1_if_gnt", 32'(if_gnt), 1);
    chk("f1_mem_gnt", 32'(mem_gnt), 0);
    chk("f1_ram_addr", 32'(ram_addr), 32'h010);
    chk("f1_stall", 32'(stall_pc), 0);
    tick();
    if_req = 1'b0;
    #1;
    chk("f1_busy_c1", 32'(busy), 1);
    chk("f1_rvalid_c1", 32'(if_rvalid), 0);
    tick();
    #1;
    chk("f1_busy_c2", 32'(busy), 1);
    chk("f1_rvalid_c2", 32'(if_rvalid), 1);
    chk("f1_rdata_c2", if_rdata, 32'hE3A01005);
    chk("f1_mem_rvalid_c2", 32'(mem_rvalid), 0);
    chk("f1_mem_rdata_c2", mem_rdata, 0);
    tick();
    #1;
    chk("f1_busy_c3", 32'(busy), 0);
    chk("f1_rvalid_c3", 32'(if_rvalid), 0);
    chk("f1_rdata_c3", if_rdata, 0);

    // collision: store wins, fetch follows, load returns stored word
    if_req = 1'b1; if_addr = 11'h020;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 11'h200; mem_wdata = 32'hDEADBEEF;
    #1;
    chk("col_mem_gnt", 32'(mem_gnt), 1);
    chk("col_if_gnt", 32'(if_gnt), 0);
    chk("col_stall", 32'(stall_pc), 1);
    chk("col_ram_we", 32'(ram_we), 1);
    chk("col_ram_addr", 32'(ram_addr), 32'h200);
    chk("col_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    #1;
    chk("col_if_gnt2", 32'(if_gnt), 1);
    chk("col_ram_addr2", 32'(ram_addr), 32'h020);
    chk("col_stall2", 32'(stall_pc), 0);
    chk("col_store_no_tag", 32'(busy), 0);
    tick();
    if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h200;
    #1;
    chk("col_ld_gnt", 32'(mem_gnt), 1);
    chk("col_ld_ram_we", 32'(ram_we), 0);
    chk("col_ld_wdata", ram_wdata, 0);
    tick();
    mem_req = 1'b0;
    #1;
    chk("col_f_rvalid", 32'(if_rvalid), 1);
    chk("col_f_rdata", if_rdata, 32'hC0DE0020);
    tick();
    #1;
    chk("col_ld_rvalid", 32'(mem_rvalid), 1);
    chk("col_ld_rdata", mem_rdata, 32'hDEADBEEF);
    chk("col_ld_if_rvalid", 32'(if_rvalid), 0);
    tick();

    // interleaved fetch / load / fetch
    if_req = 1'b1; if_addr = 11'h004;
    tick();
    if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h300;
    tick();
    mem_req = 1'b0; if_req = 1'b1; if_addr = 11'h008;
    #1;
    chk("il_c2_if_rvalid", 32'(if_rvalid), 1);
    chk("il_c2_if_rdata", if_rdata, 32'hC0DE0004);
    chk("il_c2_mem_rvalid", 32'(mem_rvalid), 0);
    tick();
    if_req = 1'b0;
    #1;
    chk("il_c3_mem_rvalid", 32'(mem_rvalid), 1);
    chk("il_c3_mem_rdata", mem_rdata, 32'hC0DE0300);
    chk("il_c3_if_rvalid", 32'(if_rvalid), 0);
    chk("il_c3_if_rdata", if_rdata, 0);
    tick();
    #1;
    chk("il_c4_if_rvalid", 32'(if_rvalid), 1);
    chk("il_c4_if_rdata", if_rdata, 32'hC0DE0008);
    chk("il_c4_mem_rvalid", 32'(mem_rvalid), 0);
    tick();

    // flush with two fetches in flight and a new fetch granted alongside
    if_req = 1'b1; if_addr = 11'h010;
    tick();
    if_addr = 11'h004;
    tick();
    flush = 1'b1; if_addr = 11'h008;
    #1;
    chk("fl_new_gnt", 32'(if_gnt), 1);
    chk("fl_last_supp", 32'(if_rvalid), 0);
    chk("fl_last_rdata", if_rdata, 0);
    tick();
    flush = 1'b0; if_req = 1'b0;
    #1;
    chk("fl_old_supp", 32'(if_rvalid), 0);
    chk("fl_busy", 32'(busy), 1);
    tick();
    #1;
    chk("fl_new_rvalid", 32'(if_rvalid), 1);
    chk("fl_new_rdata", if_rdata, 32'hC0DE0008);
    tick();
    #1;
    chk("fl_drained", 32'(busy), 0);

    // flush leaves an in-flight load alone
    if_req = 1'b1; if_addr = 11'h010;
    tick();
    if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h300;
    tick();
    mem_req = 1'b0; flush = 1'b1;
    #1;
    chk("flm_if_supp", 32'(if_rvalid), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flm_mem_rvalid", 32'(mem_rvalid), 1);
    chk("flm_mem_rdata", mem_rdata, 32'hC0DE0300);
    tick();
    #1;
    chk("flm_busy", 32'(busy), 0);

    // reset with two reads in flight
    if_req = 1'b1; if_addr = 11'h010;
    tick();
    if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h300;
    tick();
    rst = 1'b1; if_req = 1'b1;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_if_rvalid", 32'(if_rvalid), 0);
    chk("rm_mem_rvalid", 32'(mem_rvalid), 0);
    chk("rm_mem_gnt", 32'(mem_gnt), 0);
    chk("rm_if_gnt", 32'(if_gnt), 0);
    chk("rm_stall", 32'(stall_pc), 0);
    tick();
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #1;
    chk("rm_post_busy", 32'(busy), 0);
    chk("rm_post_if_rv", 32'(if_rvalid), 0);
    chk("rm_post_mem_rv", 32'(mem_rvalid), 0);
    tick();
    #1;
    chk("rm_post2_if_rv", 32'(if_rvalid), 0);
    chk("rm_post2_mem_rv", 32'(mem_rvalid), 0);
    tick();

    // sustained contention
`ifdef MEM_PORT_STARVE_GUARD_EN
    starve_exp = 6'b101111;
`else
    starve_exp = 6'b111111;
`endif
    if_req = 1'b1; if_addr = 11'h010; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h300;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("sv_mem_gnt_%0d", i), 32'(mem_gnt), 32'(starve_exp[i]));
      chk($sformatf("sv_if_gnt_%0d", i), 32'(if_gnt), 32'(!starve_exp[i]));
      chk($sformatf("sv_stall_%0d", i), 32'(stall_pc), 32'(starve_exp[i]));
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0;
    repeat (3) tick();
    #1;
    chk("end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
